// File: rtl/pal_cfg_pkg.sv
// Shared types and constants for the PAL config-chain loader.
// The CHECK/ERR states exist only when PAL_CFG_CRC_EN is defined.
package pal_cfg_pkg;

`ifdef PAL_CFG_CRC_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SHIFT, ST_CHECK, ST_APPLY, ST_DONE, ST_ERR
  } cfg_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SHIFT, ST_APPLY, ST_DONE
  } cfg_state_t;
`endif

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // Chain length: AND-plane (2*n*p) plus OR-plane (p*m).
  function automatic int cfg_bits(input int n, input int m, input int p);
    return 2 * n * p + p * m;
  endfunction

endpackage

// File: rtl/pal_cfg_crc8.sv
// Byte-wide CRC-8 step (poly 0x07), data consumed MSB-first.
// Purely combinational; no flow control of its own.
module pal_cfg_crc8
  import pal_cfg_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[7] ? ({crc_out[6:0], 1'b0} ^ CRC8_POLY) : {crc_out[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/pal_cfg_loader.sv
// Serializes config bytes LSB-first onto the PAL chain, then pulses apply.
// Latency: 1 accept + up to 8 shift cycles per byte; s_ready only in LOAD (and CHECK with PAL_CFG_CRC_EN).
// Backpressure: stalls indefinitely in LOAD without s_valid; no strobes while stalled.
module pal_cfg_loader
  import pal_cfg_pkg::*;
#(
  parameter int CFG_BITS = cfg_bits(8, 4, 11)
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       cfg_bit,
  output logic       cfg_shift,
  output logic       cfg_apply,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_W = $clog2(CFG_BITS + 1);

  cfg_state_t       state, state_nxt;
  logic [7:0]       sr;
  logic [CNT_W-1:0] bits_left;
  logic [3:0]       byte_bits;
  logic             last_bit;

  assign last_bit = (bits_left == CNT_W'(1));

`ifdef PAL_CFG_CRC_EN
  logic [7:0] crc_q, crc_nxt;

  pal_cfg_crc8 u_crc8 (
    .crc_in  (crc_q),
    .data    (s_data),
    .crc_out (crc_nxt)
  );

  assign s_ready = (state == ST_LOAD) || (state == ST_CHECK);
  assign err     = (state == ST_ERR);
  assign busy    = (state == ST_LOAD) || (state == ST_SHIFT) ||
                   (state == ST_CHECK) || (state == ST_APPLY);
`else
  assign s_ready = (state == ST_LOAD);
  assign err     = 1'b0;
  assign busy    = (state == ST_LOAD) || (state == ST_SHIFT) || (state == ST_APPLY);
`endif

  // Outputs decode the state register only, so nothing reaches them from inputs.
  assign cfg_shift = (state == ST_SHIFT);
  assign cfg_bit   = cfg_shift & sr[0];
  assign cfg_apply = (state == ST_APPLY);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: begin
        if (abort)        state_nxt = ST_IDLE;
        else if (s_valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort) state_nxt = ST_IDLE;
        else if (byte_bits == 4'd1) begin
`ifdef PAL_CFG_CRC_EN
          state_nxt = last_bit ? ST_CHECK : ST_LOAD;
`else
          state_nxt = last_bit ? ST_APPLY : ST_LOAD;
`endif
        end
      end
`ifdef PAL_CFG_CRC_EN
      ST_CHECK: begin
        if (abort)        state_nxt = ST_IDLE;
        else if (s_valid) state_nxt = (s_data == crc_q) ? ST_APPLY : ST_ERR;
      end
      ST_ERR: if (start && !abort) state_nxt = ST_LOAD;
`endif
      ST_APPLY: state_nxt = ST_DONE;
      ST_IDLE, ST_DONE: if (start && !abort) state_nxt = ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sr        <= 8'h00;
      bits_left <= '0;
      byte_bits <= 4'd0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (state_nxt == ST_SHIFT) begin
            sr        <= s_data;
            byte_bits <= (bits_left < CNT_W'(8)) ? 4'(bits_left) : 4'd8;
          end
        end
        ST_SHIFT: begin
          sr        <= {1'b0, sr[7:1]};
          bits_left <= bits_left - CNT_W'(1);
          byte_bits <= byte_bits - 4'd1;
        end
        default: begin
          if (state_nxt == ST_LOAD) bits_left <= CNT_W'(CFG_BITS);
        end
      endcase
    end
  end

`ifdef PAL_CFG_CRC_EN
  // Padding bits of the final byte are still covered by the CRC.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) crc_q <= CRC8_INIT;
    else if (state_nxt == ST_LOAD && state != ST_LOAD && state != ST_SHIFT) crc_q <= CRC8_INIT;
    else if (state == ST_LOAD && state_nxt == ST_SHIFT) crc_q <= crc_nxt;
  end
`endif

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Bench for pal_cfg_loader: 12-bit and 220-bit instances share stimulus via a select;
// set PAL_CFG_CRC_EN for the CRC build.
module tb_pal_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res_n, start, abort, s_valid, sel;
  logic [7:0] s_data;

  logic a_ready, a_bit, a_shift, a_apply, a_busy, a_done, a_err;
  logic b_ready, b_bit, b_shift, b_apply, b_busy, b_done, b_err;

  pal_cfg_loader #(.CFG_BITS(12)) u_dut12 (
    .clk(clk), .res_n(res_n), .start(start & ~sel), .abort(abort & ~sel),
    .s_data(s_data), .s_valid(s_valid & ~sel), .s_ready(a_ready),
    .cfg_bit(a_bit), .cfg_shift(a_shift), .cfg_apply(a_apply),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  pal_cfg_loader #(.CFG_BITS(220)) u_dut220 (
    .clk(clk), .res_n(res_n), .start(start & sel), .abort(abort & sel),
    .s_data(s_data), .s_valid(s_valid & sel), .s_ready(b_ready),
    .cfg_bit(b_bit), .cfg_shift(b_shift), .cfg_apply(b_apply),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  logic m_ready, m_bit, m_shift, m_apply, m_busy, m_done, m_err;
  assign m_ready = sel ? b_ready : a_ready;
  assign m_bit   = sel ? b_bit   : a_bit;
  assign m_shift = sel ? b_shift : a_shift;
  assign m_apply = sel ? b_apply : a_apply;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_err   = sel ? b_err   : a_err;

  int cfg_n;
  assign cfg_n = sel ? 220 : 12;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: record every strobed bit and apply pulse with its cycle number.
  int   cyc = 0;
  logic bitq[$];
  int   cycq[$];
  int   napply = 0;
  int   apply_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (m_shift) begin
      bitq.push_back(m_bit);
      cycq.push_back(cyc);
    end
    if (m_apply) begin
      napply++;
      apply_cyc = cyc;
    end
  end

  function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] d);
    logic fb;
    for (int k = 7; k >= 0; k--) begin
      fb = c[7] ^ d[k];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  logic [7:0] tx_q[$];
  int         stall_shifts = 0;
  int         poke_at = -1;

  // Present one byte; with gap>0, first wait for s_ready then hold s_valid low for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bit acc;
    s_valid = 1'b0;
    if (gap > 0) begin
      t = 0;
      while (!m_ready && t < 60) begin @(posedge clk); #1; t++; end
      check("ready_wait", int'(m_ready), 1);
      repeat (gap) begin
        if (m_shift) stall_shifts++;
        @(posedge clk); #1;
      end
    end
    s_data  = b;
    s_valid = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 60) begin
      acc = m_ready;
      @(posedge clk); #1;
      t++;
    end
    s_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  // Run a full load of tx_q against the currently selected instance and check it.
  task automatic do_load(input int gap, input bit bad_crc);
    logic       expq[$];
    logic [7:0] c;
    int base, abase, last_base, t, first_bad, nb;
    expq = {};
    c = 8'h00;
    nb = tx_q.size();
    foreach (tx_q[i]) begin
      for (int k = 0; k < 8; k++) if (expq.size() < cfg_n) expq.push_back(tx_q[i][k]);
      c = crc_model(c, tx_q[i]);
    end
    base = bitq.size();
    abase = napply;
    last_base = base;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    foreach (tx_q[i]) begin
      if (i == poke_at) begin start = 1'b1; @(posedge clk); #1; start = 1'b0; end
      send_byte(tx_q[i], gap);
      if (i == nb - 1) last_base = bitq.size();
    end
`ifdef PAL_CFG_CRC_EN
    send_byte(c ^ {7'b0, bad_crc}, gap);
`endif
    t = 0;
    while (!(m_done || m_err) && t < 500) begin @(posedge clk); #1; t++; end
    repeat (2) begin @(posedge clk); #1; end
    check("stream_len", bitq.size() - base, cfg_n);
    first_bad = -1;
    for (int k = 0; k < cfg_n && base + k < bitq.size(); k++)
      if (first_bad < 0 && bitq[base + k] !== expq[k]) first_bad = k;
    check("stream_first_bad_idx", first_bad, -1);
    check("last_byte_bits", bitq.size() - last_base, cfg_n - 8 * (nb - 1));
    if (gap == 0 && poke_at < 0 && bitq.size() > base)
      check("throughput_span", cycq[cycq.size() - 1] - cycq[base], cfg_n + nb - 2);
    if (!bad_crc) begin
      check("apply_count", napply - abase, 1);
      check("apply_after_last_shift", apply_cyc - cycq[cycq.size() - 1], 1);
      check("done_set", int'(m_done), 1);
      check("busy_clear", int'(m_busy), 0);
      check("err_clear", int'(m_err), 0);
    end else begin
      check("crc_bad_apply_count", napply - abase, 0);
      check("crc_bad_err", int'(m_err), 1);
      check("crc_bad_ready", int'(m_ready), 0);
      check("crc_bad_done", int'(m_done), 0);
      check("crc_bad_busy", int'(m_busy), 0);
    end
  endtask

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [11:0] exp_bits;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base, abase, t;
    logic [11:0] got12;

    vecs[0] = '{8'hA5, 8'h3C, 12'hCA5};
    vecs[1] = '{8'hFF, 8'h00, 12'h0FF};
    vecs[2] = '{8'h00, 8'hFF, 12'hF00};
    vecs[3] = '{8'h12, 8'h34, 12'h412};
    vecs[4] = '{8'h80, 8'h01, 12'h180};
    vecs[5] = '{8'h5A, 8'hF0, 12'h05A};

    res_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 8'h00; sel = 1'b0;
    #3;
    check("reset_outputs_12", int'({a_ready, a_bit, a_shift, a_apply, a_busy, a_done, a_err}), 0);
    check("reset_outputs_220", int'({b_ready, b_bit, b_shift, b_apply, b_busy, b_done, b_err}), 0);
    #10 res_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", int'(m_ready), 0);

    // Table vectors on the 12-bit chain
    foreach (vecs[i]) begin
      base = bitq.size();
      tx_q = {vecs[i].b0, vecs[i].b1};
      do_load(0, 1'b0);
      got12 = 12'h000;
      for (int k = 0; k < 12; k++) if (base + k < bitq.size()) got12[k] = bitq[base + k];
      check($sformatf("table_bits_%0d", i), int'(got12), int'(vecs[i].exp_bits));
    end

    // start in DONE clears done next cycle, then a reload still works
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    check("restart_done_clear", int'(m_done), 0);
    check("restart_busy", int'(m_busy), 1);
    tx_q = {8'hA5, 8'h3C};
    do_load(0, 1'b0);

    // start pulsed while busy is ignored
    poke_at = 1;
    tx_q = {8'h69, 8'hC3};
    do_load(0, 1'b0);
    poke_at = -1;

    // Abort during the 10th shift
    base = bitq.size(); abase = napply;
    s_data = 8'hA5; s_valid = 1'b1;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    t = 0;
    while ((bitq.size() - base) < 9 && t < 100) begin @(posedge clk); #1; t++; end
    check("abort_at_shift10", int'(m_shift), 1);
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0; s_valid = 1'b0;
    check("abort_shift_drop", int'(m_shift), 0);
    check("abort_busy", int'(m_busy), 0);
    repeat (4) begin @(posedge clk); #1; end
    check("abort_strobes", bitq.size() - base, 10);
    check("abort_no_apply", napply - abase, 0);
    check("abort_done", int'(m_done), 0);

    // Abort and start together in LOAD
    abase = napply;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    check("load_ready", int'(m_ready), 1);
    abort = 1'b1; start = 1'b1; @(posedge clk); #1; abort = 1'b0; start = 1'b0;
    check("abort_start_busy", int'(m_busy), 0);
    check("abort_start_ready", int'(m_ready), 0);
    repeat (3) begin @(posedge clk); #1; end
    check("abort_start_no_apply", napply - abase, 0);
    check("abort_start_done", int'(m_done), 0);

    // Reset asserted mid-SHIFT
    base = bitq.size();
    s_data = 8'hFF; s_valid = 1'b1;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    t = 0;
    while ((bitq.size() - base) < 3 && t < 100) begin @(posedge clk); #1; t++; end
    #1 res_n = 1'b0;
    #1 check("reset_mid_shift", int'({m_ready, m_bit, m_shift, m_apply, m_busy, m_done, m_err}), 0);
    s_valid = 1'b0;
    #10 res_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", int'(m_ready), 0);
    check("post_reset_busy", int'(m_busy), 0);

`ifdef PAL_CFG_CRC_EN
    tx_q = {8'hA5, 8'h3C};
    do_load(0, 1'b0);
    tx_q = {8'hA5, 8'h3C};
    do_load(0, 1'b1);
    tx_q = {8'hA5, 8'h3C};
    do_load(0, 1'b0);
`endif

    // Randomized loads on the 12-bit chain
    repeat (6) begin
      tx_q = {8'($urandom), 8'($urandom)};
      do_load(int'($urandom_range(0, 3)), 1'b0);
    end

    // 220-bit chain: backpressure with 5 idle cycles between bytes, then continuous
    sel = 1'b1;
    @(posedge clk); #1;
    tx_q = {};
    repeat (28) tx_q.push_back(8'($urandom));
    stall_shifts = 0;
    do_load(5, 1'b0);
    check("stall_strobes", stall_shifts, 0);
    tx_q = {};
    repeat (28) tx_q.push_back(8'($urandom));
    do_load(0, 1'b0);

`ifndef PAL_CFG_CRC_EN
    check("err_tied_low", int'(a_err | b_err), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pal_cfg_loader.md
Name: pal_cfg_loader

Overview:
- Configuration sequencer for the PAL fabric's serial config chain.
- Accepts configuration bytes over a valid/ready stream and serializes them LSB-first onto the chain, one bit per cycle with a shift strobe.
- Counts exactly CFG_BITS bits, then issues a one-cycle apply pulse so the fabric commits the new configuration.
- Sits between the host-side byte source and the PAL instance's cfg/en inputs.

Parameters:
- CFG_BITS, 220, total config chain length (2*N*P AND-plane + P*M OR-plane; 8/11/4 gives 220).
- CNT_W, $clog2(CFG_BITS+1), width of the remaining-bit counter (derived, do not override).

Ports:
- clk  in  1  system clock; all state on rising edge.
- res_n  in  1  asynchronous active-low reset.
- start  in  1  begin a load; sampled in IDLE, DONE and ERR only.
- abort  in  1  cancel an in-progress load.
- s_data  in  8  config byte; bit 0 is shifted first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts a byte this cycle.
- cfg_bit  out  1  serial config bit to the chain.
- cfg_shift  out  1  chain shift strobe; cfg_bit is valid while high.
- cfg_apply  out  1  one-cycle commit pulse to the fabric.
- busy  out  1  load in progress.
- done  out  1  last load completed and applied; sticky.
- err  out  1  last load failed its check; sticky (CRC build only).

Behaviour:
- Reset: state IDLE; all outputs 0; counters and shift register cleared. Asynchronous assertion aborts any load mid-chain; the chain is left partial and no apply is issued.
- States: IDLE, LOAD, SHIFT, [CHECK], APPLY, DONE, [ERR].
- IDLE/DONE/ERR
  - start=1 moves to LOAD next cycle.
  - Entering LOAD sets bits_left=CFG_BITS and clears done/err.
- LOAD
  - s_ready=1 and busy=1.
  - On s_valid&&s_ready: latch byte; set byte_bits=min(8, bits_left); go to SHIFT next cycle.
  - No s_valid: wait indefinitely; no strobes are emitted.
- SHIFT
  - s_ready=0; cfg_shift=1 every cycle; cfg_bit = current shift-register LSB.
  - Each cycle: register shifts right; bits_left and byte_bits decrement.
  - byte_bits reaches 0 and bits_left>0: return to LOAD.
  - bits_left reaches 0: go to APPLY (or CHECK in the CRC build).
  - Final partial byte: only the low (CFG_BITS mod 8) bits are shifted; the rest are discarded. For 220, the 28th byte shifts 4 bits.
- Throughput: 1 accept cycle + 8 shift cycles per byte. 220 bits with s_valid held high takes 28 accepts + 220 shifts.
- APPLY: cfg_apply=1 for exactly one cycle, then DONE.
- DONE: busy=0, done=1.
- abort
  - In LOAD, SHIFT or CHECK: goes to IDLE next cycle; cfg_shift drops immediately on that edge; no apply; done=0.
  - abort and start together: abort wins.
  - Ignored in IDLE, DONE and ERR.
- start while busy: ignored.
- Output timing: cfg_shift and cfg_apply are registered outputs decoded from state; no combinational path from inputs.
- s_ready: combinational from state only (state==LOAD, or CHECK in the CRC build).

Optional Feature:
- Macro: PAL_CFG_CRC_EN.
- Defined
  - CRC-8 (poly 0x07, init 0x00, MSB-first over the byte) runs over every accepted config byte, including discarded padding bits.
  - After the last bit, the loader enters CHECK with s_ready=1 and accepts one CRC byte.
  - Match: APPLY.
  - Mismatch: ERR, with err=1, done=0, busy=0, no apply. ERR holds until start.
- Not defined: no CRC logic and no CHECK/ERR states; err tied to 0.

Decomposition:
- Package pal_cfg_pkg holds:
  - state enum typedef;
  - CRC8_POLY = 8'h07 and CRC8_INIT = 8'h00;
  - function cfg_bits(n,m,p) returning 2*n*p + p*m, for top-level parameter derivation.
- One sub-module, pal_cfg_crc8: byte-wide combinational CRC step (crc_in, data -> crc_out). It is instantiated only under PAL_CFG_CRC_EN.
- The FSM, counters and shift register stay in pal_cfg_loader.

Test Plan:
- Reset: res_n low mid-SHIFT -> all outputs 0 the same cycle; after release, state IDLE and s_ready=0.
- CFG_BITS=12; start; bytes 0xA5, 0x3C with continuous valid:
  - cfg_bit sequence 1,0,1,0,0,1,0,1,0,0,1,1 across 12 cfg_shift cycles;
  - cfg_apply exactly one cycle after the last shift, then done=1, busy=0.
- Backpressure: CFG_BITS=220 with s_valid low for 5 cycles between bytes -> exactly 220 strobes total, none during stalls; the 28th byte shifts 4 bits.
- Abort on 10th shift; also abort and start asserted together -> IDLE, no cfg_apply, done=0.
- start pulsed while busy -> ignored. start in DONE -> done clears next cycle and a reload succeeds.
- PAL_CFG_CRC_EN, CFG_BITS=12, data 0xA5, 0x3C:
  - correct CRC byte -> apply and done;
  - CRC byte XOR 0x01 -> err=1, no cfg_apply, s_ready=0.
